// File: rtl/res_st_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : res_st_ctrl
// Description : Reservation-station control: slot allocation, CDB wakeup and
//               round-robin issue selection over a small entry array.
// Revision    : 1.0 - initial release
// ============================================================================
module res_st_ctrl #(
    parameter int RES_ST_DEPTH      = 8,
    parameter int PHY_RF_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH         = PHY_RF_ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [TAG_WIDTH-1:0]              alloc_rs1_tag,
    input  logic [TAG_WIDTH-1:0]              alloc_rs2_tag,
    input  logic                              alloc_rs1_rdy,
    input  logic                              alloc_rs2_rdy,
    output logic                              res_st_wr_en,
    output logic [$clog2(RES_ST_DEPTH)-1:0]   res_st_wr_addr,
    input  logic                              cdb_valid,
    input  logic [TAG_WIDTH-1:0]              cdb_tag,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [$clog2(RES_ST_DEPTH)-1:0]   issue_addr,
    output logic [$clog2(RES_ST_DEPTH):0]     occupancy,
    output logic                              full,
    output logic                              empty
);

    localparam int c_ADDR_W = $clog2(RES_ST_DEPTH);

    logic [RES_ST_DEPTH-1:0] r_valid;
    logic [RES_ST_DEPTH-1:0] r_rs1_rdy;
    logic [RES_ST_DEPTH-1:0] r_rs2_rdy;
    logic [TAG_WIDTH-1:0]    r_rs1_tag [RES_ST_DEPTH];
    logic [TAG_WIDTH-1:0]    r_rs2_tag [RES_ST_DEPTH];
    logic [c_ADDR_W:0]       r_occ;
    logic [c_ADDR_W-1:0]     r_rr_ptr;

    logic [RES_ST_DEPTH-1:0] w_elig;
    logic [c_ADDR_W-1:0]     w_free_idx;
    logic [c_ADDR_W-1:0]     w_issue_idx;
    logic [c_ADDR_W-1:0]     w_probe;
    logic                    w_full;
    logic                    w_alloc_fire;
    logic                    w_issue_fire;
    logic                    w_byp1;
    logic                    w_byp2;

    assign w_full       = (r_occ == (c_ADDR_W+1)'(RES_ST_DEPTH));
    assign w_elig       = r_valid & r_rs1_rdy & r_rs2_rdy;

    assign alloc_ready  = !w_full && !flush && !rst;
    assign res_st_wr_en = alloc_valid && alloc_ready;
    assign w_alloc_fire = res_st_wr_en;

    assign issue_valid  = (|w_elig) && !flush && !rst;
    assign w_issue_fire = issue_valid && issue_ready;

    // A result broadcast in the allocation cycle must not be lost on the new entry.
    assign w_byp1 = cdb_valid && (cdb_tag == alloc_rs1_tag);
    assign w_byp2 = cdb_valid && (cdb_tag == alloc_rs2_tag);

    assign res_st_wr_addr = w_free_idx;
    assign issue_addr     = w_issue_idx;
    assign occupancy      = r_occ;
    assign full           = w_full;
    assign empty          = (r_occ == '0);

    always_comb begin
        w_free_idx = '0;
        for (int i = RES_ST_DEPTH-1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = c_ADDR_W'(i);
            end
        end
    end

    // Downward scan so the smallest offset from rr_ptr wins; modulo is free
    // because the depth is a power of two.
    always_comb begin
        w_issue_idx = r_rr_ptr;
        w_probe     = '0;
        for (int k = RES_ST_DEPTH-1; k >= 0; k--) begin
            w_probe = r_rr_ptr + c_ADDR_W'(k);
            if (w_elig[w_probe]) begin
                w_issue_idx = w_probe;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            r_occ     <= '0;
            r_rr_ptr  <= '0;
        end else if (flush) begin
            r_valid   <= '0;
            r_occ     <= '0;
            r_rr_ptr  <= '0;
        end else begin
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                if (cdb_valid && r_valid[i]) begin
                    if (r_rs1_tag[i] == cdb_tag) r_rs1_rdy[i] <= 1'b1;
                    if (r_rs2_tag[i] == cdb_tag) r_rs2_rdy[i] <= 1'b1;
                end
            end

            if (w_issue_fire) begin
                r_valid[w_issue_idx] <= 1'b0;
                r_rr_ptr             <= w_issue_idx + 1'b1;
            end

            // The free slot is never the issuing entry, so these cannot collide.
            if (w_alloc_fire) begin
                r_valid[w_free_idx]   <= 1'b1;
                r_rs1_tag[w_free_idx] <= alloc_rs1_tag;
                r_rs2_tag[w_free_idx] <= alloc_rs2_tag;
                r_rs1_rdy[w_free_idx] <= alloc_rs1_rdy | w_byp1;
                r_rs2_rdy[w_free_idx] <= alloc_rs2_rdy | w_byp2;
            end

            case ({w_alloc_fire, w_issue_fire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/res_st_ctrl.md
RES_ST_CTRL -- requirements
Module: res_st_ctrl

Interface
REQ-001 SHALL have parameter RES_ST_DEPTH, default 8: number of reservation-station entries; power of two, minimum 2.
REQ-002 SHALL have parameter TAG_WIDTH, default PHY_RF_ADDR_WIDTH: physical-register tag width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: discard all entries.
REQ-006 SHALL have port alloc_valid, input, 1 bit: front end requests a dispatch slot.
REQ-007 SHALL have port alloc_ready, output, 1 bit: a slot is available.
REQ-008 SHALL have ports alloc_rs1_tag and alloc_rs2_tag, input, TAG_WIDTH bits each: source tags of the dispatched uop.
REQ-009 SHALL have ports alloc_rs1_rdy and alloc_rs2_rdy, input, 1 bit each: source operand already available at dispatch.
REQ-010 SHALL have port res_st_wr_en, output, 1 bit: write strobe to the reservation-station array.
REQ-011 SHALL have port res_st_wr_addr, output, $clog2(RES_ST_DEPTH) bits: array write index.
REQ-012 SHALL have ports cdb_valid (input, 1 bit) and cdb_tag (input, TAG_WIDTH bits): result-broadcast wakeup.
REQ-013 SHALL have port issue_valid, output, 1 bit: a ready entry is offered for issue.
REQ-014 SHALL have port issue_ready, input, 1 bit: back end accepts the offered entry.
REQ-015 SHALL have port issue_addr, output, $clog2(RES_ST_DEPTH) bits: offered entry index; drives the array read address.
REQ-016 SHALL have port occupancy, output, $clog2(RES_ST_DEPTH)+1 bits: number of valid entries.
REQ-017 SHALL have ports full and empty, output, 1 bit each.

Function
REQ-018 SHALL keep per-entry registers: valid, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy.
REQ-019 SHALL drive alloc_ready = !full && !flush && !rst, combinationally from registered state.
REQ-020 SHALL drive res_st_wr_addr = lowest-index entry with valid=0, using registered state only.
REQ-021 SHALL assert res_st_wr_en = alloc_valid && alloc_ready in the same cycle, with zero latency.
REQ-022 SHALL set the selected entry valid and capture tags and ready bits at the edge where allocation fires.
REQ-023 SHALL set rsN_rdy for an allocating entry if alloc_rsN_rdy=1, or if cdb_valid=1 and cdb_tag==alloc_rsN_tag in that same cycle (wakeup bypass).
REQ-024 SHALL set rsN_rdy on every valid entry whose rsN_tag==cdb_tag when cdb_valid=1; multiple entries and both operands may match in one cycle.
REQ-025 SHALL treat an entry as eligible when valid && rs1_rdy && rs2_rdy, from registered state; an entry allocated or woken in cycle N becomes eligible no earlier than cycle N+1.
REQ-026 SHALL keep a round-robin pointer rr_ptr; issue_addr SHALL be the first eligible index searching rr_ptr, rr_ptr+1, ... modulo RES_ST_DEPTH.
REQ-027 SHALL assert issue_valid iff any entry is eligible and flush=0 and rst=0.
REQ-028 SHALL keep issue_addr stable while issue_valid=1 and issue_ready=0, unless a higher-priority entry becomes eligible; the back end SHALL NOT assume stickiness.
REQ-029 SHALL, on issue_valid && issue_ready, clear that entry's valid and set rr_ptr = issue_addr+1 (wrap-around to 0) at the next edge.
REQ-030 SHALL NOT offer an entry freed in cycle N for allocation before cycle N+1.
REQ-031 SHALL, on simultaneous allocation and issue in one cycle, update occupancy by net 0; by +1 for allocation only; by -1 for issue only.
REQ-032 SHALL drive full = (occupancy==RES_ST_DEPTH) and empty = (occupancy==0), both from registered state.
REQ-033 SHALL, on flush=1, clear all valid bits and set occupancy to 0 and rr_ptr to 0 at the next edge; flush overrides allocation, issue and wakeup in that cycle.
REQ-034 SHALL ignore alloc_valid when alloc_ready=0, and issue_ready when issue_valid=0.

Reset
REQ-035 SHALL, while rst=1, drive alloc_ready=0, res_st_wr_en=0 and issue_valid=0.
REQ-036 SHALL, at the edge with rst=1, clear all valid and rdy bits, set occupancy=0, rr_ptr=0, empty=1 and full=0; tags become don't-care.
REQ-037 SHALL, on reset mid-operation, discard in-flight handshakes; alloc_ready=1 in the first cycle after rst deasserts.

Verification (RES_ST_DEPTH=4, TAG_WIDTH=6)
REQ-038 SHALL cover: reset, then 4 allocations of both-ready uops on consecutive cycles -> res_st_wr_addr 0,1,2,3; full=1 and alloc_ready=0 after the 4th; occupancy=4.
REQ-039 SHALL cover: allocate entry 0 with rs1_tag=5 not ready, then cdb_valid=1 with cdb_tag=5 one cycle later -> issue_valid=1 one cycle after the broadcast, issue_addr=0.
REQ-040 SHALL cover: alloc_rs2_tag=9 not ready while cdb_tag=9 is broadcast in the same cycle -> entry eligible at the next cycle, with no lost wakeup.
REQ-041 SHALL cover: entries 0-3 all eligible and issue_ready held at 1 -> issue_addr sequence 0,1,2,3; a re-allocated entry 0 issues after entry 3 (wrap).
REQ-042 SHALL cover: full station, issue of entry 2 and alloc_valid=1 in the same cycle -> allocation blocked that cycle; next cycle res_st_wr_addr=2 and occupancy=3.
REQ-043 SHALL cover: flush (or rst) asserted with 3 valid entries and issue_ready=1 -> no issue handshake; next cycle occupancy=0, empty=1 and alloc_ready=1.
